// File: rtl/frame_window_pkg.sv
// Shared types and address-width helpers for the frame window renderer.
package frame_window_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_SWAP
    } state_t;

    function automatic int col_w(input int fb_w);
        return $clog2(fb_w);
    endfunction

    function automatic int row_w(input int fb_h);
        return $clog2(fb_h);
    endfunction

    // One extra top bit selects the buffer when double buffering is enabled.
    function automatic int addr_w(input int fb_w, input int fb_h, input int double_buf);
        return $clog2(fb_w * fb_h) + double_buf;
    endfunction

endpackage

// File: rtl/fb_dual_port_ram.sv
// Simple dual-port frame store: write port A, registered read port B with enable.
module fb_dual_port_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             re_b,
    input  logic [AW-1:0]    addr_b,
    output logic [WIDTH-1:0] dout_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // Read-before-write: a same-address read during a write returns the old word.
    always_ff @(posedge clock) begin
        if (re_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/frame_window_renderer.sv
// Fills a (double-buffered) frame store from an image source and scans the
// front buffer out inside a screen window, with background colour elsewhere.
module frame_window_renderer
    import frame_window_pkg::*;
#(
    parameter int             FB_W       = 256,
    parameter int             FB_H       = 240,
    parameter int             WIN_X      = 192,
    parameter int             WIN_Y      = 135,
    parameter int             PIX_W      = 3,
    parameter logic [PIX_W-1:0] BG_COLOR = '0,
    parameter int             DOUBLE_BUF = 1,
    localparam int            COL_W      = col_w(FB_W),
    localparam int            ROW_W      = row_w(FB_H)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             src_req,
    output logic [COL_W-1:0] src_col,
    output logic [ROW_W-1:0] src_row,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_pixel,
    input  logic             vblank,
    input  logic [10:0]      horReg,
    input  logic [9:0]       verReg,
    output logic [PIX_W-1:0] rgb
);

    localparam int ADDR_W = addr_w(FB_W, FB_H, DOUBLE_BUF);
    localparam int PA_W   = ADDR_W - DOUBLE_BUF;
    localparam int DEPTH  = 1 << ADDR_W;

    state_t           state_reg;
    logic             front_idx_reg;
    logic             vblank_prev_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic             src_req_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             in_win_reg;
    logic [PIX_W-1:0] rgb_reg;

    logic              accept;
    logic              last_col;
    logic              last_row;
    logic [PA_W-1:0]   wr_pix;
    logic [PA_W-1:0]   rd_pix;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_win;
    logic [10:0]       win_x_off;
    logic [9:0]        win_y_off;
    logic [PIX_W-1:0]  ram_q;

    assign accept   = src_req_reg && src_valid;
    assign last_col = (col_reg == COL_W'(FB_W - 1));
    assign last_row = (row_reg == ROW_W'(FB_H - 1));
    assign wr_pix   = PA_W'(32'(row_reg) * FB_W + 32'(col_reg));

    // Offsets wrap outside the window; they only matter when in_win is set.
    assign win_x_off = horReg - 11'(WIN_X);
    assign win_y_off = verReg - 10'(WIN_Y);
    assign rd_pix    = PA_W'(32'(win_y_off) * FB_W + 32'(win_x_off));
    assign in_win    = (32'(horReg) >= WIN_X) && (32'(horReg) < WIN_X + FB_W) &&
                       (32'(verReg) >= WIN_Y) && (32'(verReg) < WIN_Y + FB_H);

    generate
        if (DOUBLE_BUF != 0) begin : g_dbuf
            assign wr_addr = {~front_idx_reg, wr_pix};
            assign rd_addr = {front_idx_reg, rd_pix};
        end else begin : g_sbuf
            assign wr_addr = wr_pix;
            assign rd_addr = rd_pix;
        end
    endgenerate

    fb_dual_port_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W)
    ) u_ram (
        .clock  (clock),
        .we_a   (accept),
        .addr_a (wr_addr),
        .din_a  (src_pixel),
        .re_b   (in_win),
        .addr_b (rd_addr),
        .dout_b (ram_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            front_idx_reg   <= 1'b0;
            vblank_prev_reg <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            src_req_reg     <= 1'b0;
            col_reg         <= '0;
            row_reg         <= '0;
        end else begin
            frame_done_reg  <= 1'b0;
            vblank_prev_reg <= vblank;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= FILL;
                        col_reg     <= '0;
                        row_reg     <= '0;
                        busy_reg    <= 1'b1;
                        src_req_reg <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (last_col) begin
                            col_reg <= '0;
                            if (last_row) begin
                                row_reg     <= '0;
                                src_req_reg <= 1'b0;
                                if (DOUBLE_BUF != 0) begin
                                    state_reg <= WAIT_SWAP;
                                end else begin
                                    state_reg      <= IDLE;
                                    busy_reg       <= 1'b0;
                                    frame_done_reg <= 1'b1;
                                end
                            end else begin
                                row_reg <= row_reg + ROW_W'(1);
                            end
                        end else begin
                            col_reg <= col_reg + COL_W'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    // Only a fresh rising edge swaps, so a redraw never lands mid-blank.
                    if (vblank && !vblank_prev_reg) begin
                        front_idx_reg  <= ~front_idx_reg;
                        frame_done_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_win_reg <= 1'b0;
            rgb_reg    <= BG_COLOR;
        end else begin
            in_win_reg <= in_win;
            rgb_reg    <= in_win_reg ? ram_q : BG_COLOR;
        end
    end

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign src_req    = src_req_reg;
    assign src_col    = col_reg;
    assign src_row    = row_reg;
    assign rgb        = rgb_reg;

endmodule

// File: tb/tb_frame_window_renderer.sv
// Directed sequence with randomized source against a two-buffer image model.
module tb_frame_window_renderer;

    localparam int         FB_W  = 32;
    localparam int         FB_H  = 24;
    localparam int         WIN_X = 192;
    localparam int         WIN_Y = 135;
    localparam logic [2:0] BG    = 3'd7;
    localparam int         N     = FB_W * FB_H;

    logic        clock, reset_n, start, busy, frame_done, src_req, src_valid, vblank;
    logic [4:0]  src_col, src_row;
    logic [2:0]  src_pixel, rgb;
    logic [10:0] horReg;
    logic [9:0]  verReg;

    frame_window_renderer #(
        .FB_W(FB_W), .FB_H(FB_H), .WIN_X(WIN_X), .WIN_Y(WIN_Y),
        .PIX_W(3), .BG_COLOR(BG), .DOUBLE_BUF(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy),
        .frame_done(frame_done), .src_req(src_req), .src_col(src_col),
        .src_row(src_row), .src_valid(src_valid), .src_pixel(src_pixel),
        .vblank(vblank), .horReg(horReg), .verReg(verReg), .rgb(rgb)
    );

    // Image model: two physical buffers plus which one is on screen.
    logic [2:0] phys [2][FB_H][FB_W];
    int front = 0;
    int src_mode = 0;
    int acc_total = 0;
    int order_err = 0;
    int fill_pos = 0;
    int fd_count = 0;
    int tests = 0;
    int fails = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Source: decides valid/pixel at the negedge; a pixel presented with src_req
    // high is accepted at the next posedge, so it is recorded into the model here.
    initial begin
        logic       v;
        logic [2:0] p;
        src_valid = 1'b0;
        src_pixel = 3'd0;
        forever begin
            @(negedge clock);
            if (frame_done) begin
                fd_count++;
                front = 1 - front;
            end
            if (src_req && reset_n) begin
                v = (src_mode == 1) ? ($urandom_range(0, 99) >= 30) : 1'b1;
                p = 3'($urandom_range(0, 7));
                if (v) begin
                    if (src_mode == 0) p = 3'(src_col ^ src_row);
                    else if (src_mode == 2) p = 3'd5;
                    if (int'(src_col) != fill_pos % FB_W || int'(src_row) != fill_pos / FB_W)
                        order_err++;
                    phys[1 - front][src_row][src_col] = p;
                    fill_pos++;
                    acc_total++;
                end
                src_valid = v;
                src_pixel = p;
            end else begin
                fill_pos  = 0;
                src_valid = 1'($urandom_range(0, 1));
                src_pixel = 3'($urandom_range(0, 7));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_pix(input int h, input int v);
        if (h >= WIN_X && h < WIN_X + FB_W && v >= WIN_Y && v < WIN_Y + FB_H)
            return phys[front][v - WIN_Y][h - WIN_X];
        return BG;
    endfunction

    task automatic check_pix(input string tag, input int h, input int v, input logic [2:0] exp);
        @(negedge clock);
        horReg = 11'(h);
        verReg = 10'(v);
        @(negedge clock);
        @(negedge clock);
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic sweep(input string tag);
        int bad = 0;
        for (int v = 0; v < FB_H; v++) begin
            for (int h = 0; h < FB_W; h++) begin
                @(negedge clock);
                horReg = 11'(WIN_X + h);
                verReg = 10'(WIN_Y + v);
                @(negedge clock);
                @(negedge clock);
                if (rgb !== model_pix(WIN_X + h, WIN_Y + v)) bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    task automatic run_fill(input int md, input bit extra_start, input string tag);
        int base, ebase, busy_low, cyc;
        bit sent;
        src_mode = md;
        base     = acc_total;
        ebase    = order_err;
        busy_low = 0;
        sent     = 1'b0;
        cyc      = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (src_req && cyc < 20 * N) begin
            if (!busy) busy_low++;
            if (extra_start && !sent && acc_total - base >= N / 2) begin
                start = 1'b1;
                sent  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check({tag, " accepts"}, acc_total - base, N);
        check({tag, " order"}, order_err - ebase, 0);
        check({tag, " busy_held"}, busy_low, 0);
        check({tag, " busy_after_fill"}, 32'(busy), 1);
    endtask

    task automatic do_swap(input string tag);
        int fd0 = fd_count;
        repeat (4) @(negedge clock);
        check({tag, " no_early_done"}, fd_count - fd0, 0);
        check({tag, " busy_wait"}, 32'(busy), 1);
        vblank = 1'b1;
        @(negedge clock);
        check({tag, " done_pulse"}, 32'(frame_done), 1);
        check({tag, " busy_clear"}, 32'(busy), 0);
        @(negedge clock);
        check({tag, " done_one_cycle"}, 32'(frame_done), 0);
        repeat (2) @(negedge clock);
        vblank = 1'b0;
        @(negedge clock);
        check({tag, " idle_no_req"}, 32'(src_req), 0);
    endtask

    initial begin
        int base, fd0, cyc;
        reset_n = 1'b0;
        start   = 1'b0;
        vblank  = 1'b0;
        horReg  = 11'd300;
        verReg  = 10'd200;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset rgb", 32'(rgb), 32'(BG));
        check("reset busy", 32'(busy), 0);
        check("reset src_req", 32'(src_req), 0);
        check("reset frame_done", 32'(frame_done), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle busy", 32'(busy), 0);
        check("idle src_req", 32'(src_req), 0);
        check_pix("outside rgb", 0, 0, BG);

        // Full fill with the col^row pattern, no stalls
        run_fill(0, 1'b0, "fill1");
        do_swap("swap1");
        check_pix("win(5,3)", WIN_X + 5, WIN_Y + 3, 3'd6);
        check_pix("left edge", WIN_X - 1, WIN_Y + 3, BG);
        check_pix("right edge", WIN_X + FB_W, WIN_Y + 3, BG);
        check_pix("bottom edge", WIN_X + 5, WIN_Y + FB_H, BG);
        check_pix("top-left", WIN_X, WIN_Y, 3'd0);
        check_pix("bottom-right", WIN_X + FB_W - 1, WIN_Y + FB_H - 1, 3'((FB_W - 1) ^ (FB_H - 1)));
        sweep("sweep1");

        // Random stalls and random pixels, with an ignored start mid-fill
        run_fill(1, 1'b1, "fill2");
        do_swap("swap2");
        repeat (5) @(negedge clock);
        check("no queued start req", 32'(src_req), 0);
        check("no queued start busy", 32'(busy), 0);
        sweep("sweep2");

        // Constant 5 with vblank already high on entry to the swap wait
        vblank = 1'b1;
        fd0 = fd_count;
        run_fill(2, 1'b0, "fill3");
        repeat (6) @(negedge clock);
        check("vblank high no swap", fd_count - fd0, 0);
        check_pix("old image kept", WIN_X + 7, WIN_Y + 2, model_pix(WIN_X + 7, WIN_Y + 2));
        vblank = 1'b0;
        repeat (3) @(negedge clock);
        check("vblank fall no swap", fd_count - fd0, 0);
        check_pix("old image still", WIN_X + 1, WIN_Y + 9, model_pix(WIN_X + 1, WIN_Y + 9));
        do_swap("swap3");
        check_pix("const 5 shown", WIN_X + 10, WIN_Y + 10, 3'd5);
        sweep("sweep3");

        // Reset in the middle of a fill
        src_mode = 0;
        base = acc_total;
        fd0 = fd_count;
        cyc = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (acc_total - base < 100 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        check("partial fill reached", 32'(acc_total - base >= 100), 1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        front = 0;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort src_req", 32'(src_req), 0);
        check("abort frame_done", 32'(frame_done), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("abort no done", fd_count - fd0, 0);
        check("abort idle", 32'(busy), 0);
        sweep("sweep front0");

        // Fresh fill after the abort
        run_fill(1, 1'b0, "fill4");
        do_swap("swap4");
        sweep("sweep4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
